// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: single-beat memory request/response bus.
//   valid  request pulse, one cycle
//   instr  instruction-access flag
//   addr   byte address (32)
//   wdata  write data (32)
//   wstrb  byte strobes (4), 0 means read
//   ready  response pulse
//   rdata  response data (32)
// master issues requests and receives responses; slave does the opposite.
interface mem_arbiter_if;
  logic        valid;
  logic        instr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;

  modport master (
    output valid, instr, addr, wdata, wstrb,
    input  ready, rdata
  );

  modport slave (
    input  valid, instr, addr, wdata, wstrb,
    output ready, rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory bus between the fetch port and the
// load/store port. One transaction is outstanding at a time; each port
// can park one request in its pending slot while the bus is busy.
// Ports:
//   clk   clock
//   rst   synchronous, active-low reset
//   imem  fetch port (slave side of the bus)
//   dmem  load/store port (slave side of the bus)
//   mem   downstream memory bus (master side)
//
// state  | meaning
// -------+------------------------------------------
// IDLE   | no transaction on the bus
// BUSY_I | fetch transaction outstanding
// BUSY_D | load/store transaction outstanding
module mem_arbiter (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  imem,
  mem_arbiter_if.slave  dmem,
  mem_arbiter_if.master mem
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  typedef struct packed {
    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  state_t state, state_nxt;
  // 0: fetch was granted last, 1: load/store was granted last
  logic   last_d, last_d_nxt;
  req_t   i_slot, i_slot_nxt, d_slot, d_slot_nxt;
  req_t   i_live, d_live, win_req;
  logic   i_cand, d_cand, grant_i, grant_d;
  logic        imem_ready_c, dmem_ready_c;
  logic [31:0] imem_rdata_c, dmem_rdata_c;

  assign i_live = {imem.valid, imem.instr, imem.addr, imem.wdata, imem.wstrb};
  assign d_live = {dmem.valid, dmem.instr, dmem.addr, dmem.wdata, dmem.wstrb};
  assign i_cand = i_live.valid | i_slot.valid;
  assign d_cand = d_live.valid | d_slot.valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      last_d <= 1'b0;
      i_slot <= '0;
      d_slot <= '0;
    end else begin
      state  <= state_nxt;
      last_d <= last_d_nxt;
      i_slot <= i_slot_nxt;
      d_slot <= d_slot_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    last_d_nxt   = last_d;
    grant_i      = 1'b0;
    grant_d      = 1'b0;
    win_req      = '0;
    imem_ready_c = 1'b0;
    dmem_ready_c = 1'b0;
    imem_rdata_c = '0;
    dmem_rdata_c = '0;

    case (state)
      IDLE: begin
        // On a tie the port that did not win last time goes first.
        if (d_cand && (!i_cand || !last_d)) begin
          grant_d = 1'b1;
        end else if (i_cand) begin
          grant_i = 1'b1;
        end
        if (grant_d) begin
          win_req    = d_slot.valid ? d_slot : d_live;
          state_nxt  = BUSY_D;
          last_d_nxt = 1'b1;
        end else if (grant_i) begin
          win_req    = i_slot.valid ? i_slot : i_live;
          state_nxt  = BUSY_I;
          last_d_nxt = 1'b0;
        end
      end
      BUSY_I: begin
        if (mem.ready) begin
          imem_ready_c = 1'b1;
          imem_rdata_c = mem.rdata;
          state_nxt    = IDLE;
        end
      end
      BUSY_D: begin
        if (mem.ready) begin
          dmem_ready_c = 1'b1;
          dmem_rdata_c = mem.rdata;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A granted port consumed its source: the slot if full, otherwise the
    // live request (slot already empty). Any other live request is parked.
    i_slot_nxt = i_slot;
    if (grant_i) begin
      i_slot_nxt.valid = 1'b0;
    end else if (i_live.valid) begin
      i_slot_nxt = i_live;
    end

    d_slot_nxt = d_slot;
    if (grant_d) begin
      d_slot_nxt.valid = 1'b0;
    end else if (d_live.valid) begin
      d_slot_nxt = d_live;
    end

    // Outputs are forced quiet while reset is held, whatever the inputs.
    if (!rst) begin
      win_req      = '0;
      imem_ready_c = 1'b0;
      dmem_ready_c = 1'b0;
      imem_rdata_c = '0;
      dmem_rdata_c = '0;
    end
  end

  assign mem.valid  = win_req.valid;
  assign mem.instr  = win_req.instr;
  assign mem.addr   = win_req.addr;
  assign mem.wdata  = win_req.wdata;
  assign mem.wstrb  = win_req.wstrb;
  assign imem.ready = imem_ready_c;
  assign imem.rdata = imem_rdata_c;
  assign dmem.ready = dmem_ready_c;
  assign dmem.rdata = dmem_rdata_c;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed test of mem_arbiter. Inputs change 1 time unit
// after the rising edge; outputs are checked on the falling edge.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail = 0;
  int   mv_count;

  always #5 clk = ~clk;

  mem_arbiter_if imem_bus ();
  mem_arbiter_if dmem_bus ();
  mem_arbiter_if mem_bus ();

  mem_arbiter dut (
    .clk  (clk),
    .rst  (rst),
    .imem (imem_bus),
    .dmem (dmem_bus),
    .mem  (mem_bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    imem_bus.valid = 1'b0; imem_bus.instr = 1'b0; imem_bus.addr = '0;
    imem_bus.wdata = '0;   imem_bus.wstrb = '0;
    dmem_bus.valid = 1'b0; dmem_bus.instr = 1'b0; dmem_bus.addr = '0;
    dmem_bus.wdata = '0;   dmem_bus.wstrb = '0;
    mem_bus.ready  = 1'b0; mem_bus.rdata  = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive_i(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
    imem_bus.valid = 1'b1; imem_bus.instr = 1'b1; imem_bus.addr = addr;
    imem_bus.wdata = wdata; imem_bus.wstrb = wstrb;
  endtask

  task automatic drive_d(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
    dmem_bus.valid = 1'b1; dmem_bus.instr = 1'b0; dmem_bus.addr = addr;
    dmem_bus.wdata = wdata; dmem_bus.wstrb = wstrb;
  endtask

  task automatic respond(input logic [31:0] rdata);
    mem_bus.ready = 1'b1;
    mem_bus.rdata = rdata;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset holds every output low even with all inputs active.
    rst = 1'b0;
    clear_inputs();
    #1;
    drive_i(32'h100, 32'h0, 4'h0);
    drive_d(32'h8000, 32'h1234, 4'hF);
    respond(32'hAA);
    sample();
    chk("rst_mem_valid",  mem_bus.valid,  0);
    chk("rst_mem_addr",   mem_bus.addr,   0);
    chk("rst_imem_ready", imem_bus.ready, 0);
    chk("rst_dmem_ready", dmem_bus.ready, 0);
    repeat (2) next_cycle();
    rst = 1'b1;

    // Single fetch.
    drive_i(32'h100, 32'h0, 4'h0);
    sample();
    chk("f_mem_valid", mem_bus.valid, 1);
    chk("f_mem_addr",  mem_bus.addr,  32'h100);
    chk("f_mem_instr", mem_bus.instr, 1);
    chk("f_dmem_ready0", dmem_bus.ready, 0);
    next_cycle();
    sample();
    chk("f_busy_valid", mem_bus.valid, 0);
    chk("f_busy_addr",  mem_bus.addr,  0);
    chk("f_busy_iready", imem_bus.ready, 0);
    next_cycle();
    respond(32'h13);
    sample();
    chk("f_imem_ready", imem_bus.ready, 1);
    chk("f_imem_rdata", imem_bus.rdata, 32'h13);
    chk("f_dmem_ready2", dmem_bus.ready, 0);
    chk("f_dmem_rdata2", dmem_bus.rdata, 0);
    next_cycle();
    // Stray mem_ready in IDLE is dropped.
    respond(32'h55);
    sample();
    chk("idle_drop_iready", imem_bus.ready, 0);
    chk("idle_drop_irdata", imem_bus.rdata, 0);
    chk("idle_drop_dready", dmem_bus.ready, 0);
    next_cycle();

    // Simultaneous requests from reset: dmem wins the first tie.
    apply_reset();
    drive_i(32'h200, 32'h0, 4'h0);
    drive_d(32'h8000, 32'hDEADBEEF, 4'hF);
    sample();
    chk("sim_valid", mem_bus.valid, 1);
    chk("sim_addr",  mem_bus.addr,  32'h8000);
    chk("sim_wdata", mem_bus.wdata, 32'hDEADBEEF);
    chk("sim_wstrb", mem_bus.wstrb, 4'hF);
    chk("sim_instr", mem_bus.instr, 0);
    next_cycle();
    respond(32'h11);
    sample();
    chk("sim_dready", dmem_bus.ready, 1);
    chk("sim_drdata", dmem_bus.rdata, 32'h11);
    chk("sim_iready0", imem_bus.ready, 0);
    chk("sim_valid_busy", mem_bus.valid, 0);
    next_cycle();
    sample();
    chk("sim_slot_valid", mem_bus.valid, 1);
    chk("sim_slot_addr",  mem_bus.addr,  32'h200);
    chk("sim_slot_wstrb", mem_bus.wstrb, 0);
    chk("sim_slot_instr", mem_bus.instr, 1);
    next_cycle();
    respond(32'h22);
    sample();
    chk("sim_iready", imem_bus.ready, 1);
    chk("sim_irdata", imem_bus.rdata, 32'h22);
    next_cycle();
    sample();
    chk("sim_slot_cleared", mem_bus.valid, 0);
    next_cycle();

    // Request arriving while a fetch is outstanding.
    drive_i(32'h300, 32'h0, 4'h0);
    sample();
    chk("q_fetch_valid", mem_bus.valid, 1);
    chk("q_fetch_addr",  mem_bus.addr,  32'h300);
    next_cycle();
    drive_d(32'h8004, 32'h0, 4'h0);
    sample();
    chk("q_busy_valid0", mem_bus.valid, 0);
    next_cycle();
    sample();
    chk("q_busy_valid1", mem_bus.valid, 0);
    next_cycle();
    sample();
    chk("q_busy_valid2", mem_bus.valid, 0);
    next_cycle();
    respond(32'h33);
    sample();
    chk("q_iready", imem_bus.ready, 1);
    chk("q_valid_at_ready", mem_bus.valid, 0);
    next_cycle();
    sample();
    chk("q_d_valid", mem_bus.valid, 1);
    chk("q_d_addr",  mem_bus.addr,  32'h8004);
    next_cycle();
    respond(32'h44);
    sample();
    chk("q_dready", dmem_bus.ready, 1);
    chk("q_drdata", dmem_bus.rdata, 32'h44);
    next_cycle();

    // Round robin: the port just served re-requests in the next cycle.
    apply_reset();
    for (int t = 0; t < 6; t++) begin
      if (t == 0) begin
        drive_i(32'h400, 32'h0, 4'h0);
        drive_d(32'h9000, 32'h0, 4'h0);
      end else if (t % 2 == 1) begin
        drive_d(32'h9000, 32'h0, 4'h0);
      end else begin
        drive_i(32'h400, 32'h0, 4'h0);
      end
      sample();
      chk("rr_valid", mem_bus.valid, 1);
      chk("rr_addr", mem_bus.addr, (t % 2 == 0) ? 32'h9000 : 32'h400);
      next_cycle();
      respond(32'(t));
      sample();
      chk("rr_dready", dmem_bus.ready, (t % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_iready", imem_bus.ready, (t % 2 == 0) ? 32'd0 : 32'd1);
      next_cycle();
    end
    sample();
    chk("rr_drain_addr", mem_bus.addr, 32'h9000);
    next_cycle();
    respond(32'h66);
    sample();
    chk("rr_drain_dready", dmem_bus.ready, 1);
    next_cycle();

    // Reset while BUSY_D with a queued fetch.
    apply_reset();
    drive_i(32'h600, 32'h0, 4'h0);
    drive_d(32'h9100, 32'h0, 4'h0);
    sample();
    chk("mr_issue_addr", mem_bus.addr, 32'h9100);
    next_cycle();
    rst = 1'b0;
    sample();
    chk("mr_rst_valid",  mem_bus.valid,  0);
    chk("mr_rst_iready", imem_bus.ready, 0);
    chk("mr_rst_dready", dmem_bus.ready, 0);
    next_cycle();
    rst = 1'b1;
    sample();
    chk("mr_slot_gone", mem_bus.valid, 0);
    next_cycle();
    respond(32'h77);
    sample();
    chk("mr_late_iready", imem_bus.ready, 0);
    chk("mr_late_dready", dmem_bus.ready, 0);
    chk("mr_late_valid",  mem_bus.valid,  0);
    next_cycle();
    sample();
    chk("mr_after_valid", mem_bus.valid, 0);
    next_cycle();

    // Downstream stall of 10 cycles.
    drive_i(32'h500, 32'h0, 4'h0);
    mv_count = 0;
    sample();
    if (mem_bus.valid === 1'b1) mv_count++;
    chk("st_iready_issue", imem_bus.ready, 0);
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      sample();
      if (mem_bus.valid === 1'b1) mv_count++;
      chk("st_iready_wait", imem_bus.ready, 0);
    end
    chk("st_valid_pulses", 32'(mv_count), 1);
    next_cycle();
    respond(32'h99);
    sample();
    chk("st_iready", imem_bus.ready, 1);
    chk("st_irdata", imem_bus.rdata, 32'h99);
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port to one-port memory arbiter that shares a single memory bus between the instruction-fetch port and the load/store port of the core. It sits between the fetch and execute stages' memory interfaces and the external memory or bus bridge. It accepts single-cycle requests, queues one request per port while the bus is busy, and routes each response back to the port that issued it. Only one transaction is outstanding on the bus at a time.

## Interface
- No parameters. Address and data width: 32. Strobe width: 4.
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- imem_valid  in  1  fetch request pulse, one cycle
- imem_instr  in  1  instruction-access flag
- imem_addr  in  32  fetch address
- imem_wdata  in  32  write data, unused for fetch but carried
- imem_wstrb  in  4  byte strobes, 0 means read
- imem_ready  out  1  response pulse to the fetch port
- imem_rdata  out  32  response data
- dmem_valid, dmem_instr, dmem_addr, dmem_wdata, dmem_wstrb  in  1/1/32/32/4  load/store request, same meaning as the fetch port
- dmem_ready  out  1  response pulse to the load/store port
- dmem_rdata  out  32  response data
- mem_valid  out  1  downstream request pulse, one cycle
- mem_instr  out  1  forwarded instruction-access flag
- mem_addr  out  32  forwarded address
- mem_wdata  out  32  forwarded write data
- mem_wstrb  out  4  forwarded byte strobes
- mem_ready  in  1  downstream response pulse
- mem_rdata  in  32  downstream response data

## Operation
- State machine states:
  - IDLE: no transaction on the bus.
  - BUSY_I: a fetch transaction is outstanding.
  - BUSY_D: a load/store transaction is outstanding.
- Each port has one pending slot holding valid, instr, addr, wdata and wstrb.
- Request sources, per port: a live request (the port's valid input high this cycle) or a queued request (that port's pending slot is full).
- IDLE:
  - Compute the candidates for each port. A port is a candidate if it has a live or a queued request.
  - If only one port is a candidate, that port wins.
  - If both ports are candidates, the winner is the port not in last_grant.
  - last_grant resets to I, so dmem wins the first tie.
  - The winner's request drives mem_* combinationally with mem_valid=1 in the same cycle.
  - The state moves to BUSY_I or BUSY_D, and last_grant is set to the winner.
  - If the winner's request came from its slot, the slot is cleared.
  - A losing live request is written into its port's pending slot.
- BUSY_x:
  - mem_valid=0.
  - Any live request on either port is written into that port's pending slot.
  - When mem_ready=1, x_ready=1 and x_rdata=mem_rdata in the same cycle, and the state returns to IDLE.
  - The other port's ready output stays 0.
- When a ready output is 0, its rdata output is 0.
- A live request on a port whose slot is already full, or whose transaction is already outstanding, is a protocol violation. Behaviour is undefined and the bench must not drive it.
- A mem_ready pulse received in IDLE is dropped. No port ready is asserted.
- mem_* address, data and strobe outputs are 0 whenever mem_valid=0.

## Timing
- Reset:
  - state=IDLE, both pending slots empty, last_grant=I.
  - mem_valid, imem_ready and dmem_ready are 0 while rst=0, regardless of the inputs.
- Idle bus with a live request: mem_valid is asserted in the same cycle, with 0-cycle added latency.
- Response: x_ready is asserted in the same cycle as mem_ready. Total latency equals the downstream latency.
- A queued request issues in the cycle after the mem_ready of the previous transaction. This gives a minimum gap of 1 cycle between bus requests.
- Reset asserted mid-transaction:
  - State and pending slots are cleared.
  - A later mem_ready for the aborted transaction arrives in IDLE and is dropped.

## Test plan
- Single fetch:
  - Stimulus: imem_valid with addr=0x100 at cycle 0; mem_ready with rdata=0x00000013 at cycle 2.
  - Required: mem_valid=1 and mem_addr=0x100 at cycle 0; imem_ready=1 and imem_rdata=0x13 at cycle 2; dmem_ready=0 throughout.
- Simultaneous requests from reset:
  - Stimulus: imem_valid with addr=0x200 and dmem_valid with addr=0x8000, wstrb=0xF, wdata=0xDEADBEEF, both at cycle 0; mem_ready at cycle 1 and again at cycle 3.
  - Required: the dmem write issues at cycle 0; dmem_ready=1 at cycle 1; the fetch of 0x200 issues from its slot at cycle 2; imem_ready=1 at cycle 3.
- Request during busy:
  - Stimulus: a fetch is outstanding; dmem_valid with addr=0x8004 arrives and is queued; mem_ready arrives 3 cycles later.
  - Required: mem_valid stays 0 while busy; the dmem request issues in the cycle after mem_ready.
- Round-robin fairness:
  - Stimulus: both ports keep re-requesting immediately after each response, for 6 transactions.
  - Required: grants alternate D, I, D, I, D, I.
- Reset mid-transaction:
  - Stimulus: assert rst=0 while in BUSY_D with a queued fetch; release rst; then pulse mem_ready.
  - Required: no ready output is asserted, and mem_valid stays 0.
- Downstream stall:
  - Stimulus: mem_ready withheld for 10 cycles after a fetch.
  - Required: imem_ready stays 0 and exactly one mem_valid pulse is seen.
